// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter thresholds,
// BTB entry layout and PC index/tag extraction.
package bp_pkg;

  // Widest PC and counter the entry layout can hold; instances use the low bits.
  localparam int unsigned BTB_ADDR_MAX = 64;
  localparam int unsigned BTB_CTR_MAX  = 16;

  typedef struct packed {
    logic                    valid;
    logic                    jmp;
    logic [BTB_ADDR_MAX-1:0] tag;
    logic [BTB_ADDR_MAX-1:0] target;
    logic [BTB_CTR_MAX-1:0]  ctr;
  } btb_entry_t;

  // Weakly-taken threshold: the counter MSB alone.
  function automatic int unsigned ctr_wt(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Weakly not-taken: one below the taken threshold.
  function automatic int unsigned ctr_wnt(input int unsigned bits);
    return ctr_wt(bits) - 1;
  endfunction

  // Word-aligned table index: pc[idx_w+1:2].
  function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next value of a saturating up/down counter with a force-to-max input.
module bp_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken,
  input  logic                force_max,
  output logic [CTR_BITS-1:0] ctr_o
);

  // Jumps pin the counter high; otherwise step toward the outcome and stick at the rails.
  always_comb begin
    ctr_o = ctr_i;
    if (force_max) begin
      ctr_o = '1;
    end else if (taken) begin
      if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with saturating counters,
// an IF->ID shadow of the prediction, ID-stage mispredict detection and stats.
// All state moves on the falling clock edge, in step with the pipeline registers.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned STAT_W   = 32,
  parameter int unsigned MODE     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] next_pc,
  input  logic              if_stall,
  input  logic              id_flush,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_jump,
  output logic              mispredict,
  output logic [ADDR_W-1:0] recover_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;
  localparam logic        USE_BTB = (MODE != 0);

  localparam logic [CTR_BITS-1:0] CTR_WT_V  = CTR_BITS'(ctr_wt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT_V = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX_V = '1;

  localparam btb_entry_t ENTRY_RST = '{
    valid:  1'b0,
    jmp:    1'b0,
    tag:    '0,
    target: '0,
    ctr:    BTB_CTR_MAX'(CTR_WNT_V)
  };

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];

  logic              shadow_valid_q, shadow_valid_d;
  logic              shadow_taken_q, shadow_taken_d;
  logic [ADDR_W-1:0] shadow_npc_q,   shadow_npc_d;

  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  logic [IDX_W-1:0]    lk_idx, upd_idx;
  logic [TAG_W-1:0]    lk_tag, upd_tag;
  btb_entry_t          lk_e;
  logic [CTR_BITS-1:0] lk_ctr;
  logic                lk_hit;
  logic                upd_hit;
  logic [CTR_BITS-1:0] upd_ctr_cur, upd_ctr_nxt;
  logic                id_pred_taken;
  logic [ADDR_W-1:0]   id_pred_npc;

  assign lk_idx  = IDX_W'(pc_idx(64'(lk_pc), IDX_W));
  assign lk_tag  = TAG_W'(pc_tag(64'(lk_pc), IDX_W));
  assign upd_idx = IDX_W'(pc_idx(64'(upd_pc), IDX_W));
  assign upd_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

  // IF lookup: zero-latency read of the pre-edge table contents.
  always_comb begin
    lk_e       = btb_q[lk_idx];
    lk_ctr     = CTR_BITS'(lk_e.ctr);
    lk_hit     = lk_valid & lk_e.valid & (lk_e.tag == BTB_ADDR_MAX'(lk_tag));
    pred_taken = USE_BTB & lk_hit & (lk_ctr[CTR_BITS-1] | lk_e.jmp);
    next_pc    = pred_taken ? ADDR_W'(lk_e.target) : lk_pc + ADDR_W'(4);
  end

  // ID resolution: compare the carried prediction with the actual outcome.
  always_comb begin
    id_pred_taken = shadow_valid_q & shadow_taken_q;
    id_pred_npc   = shadow_valid_q ? shadow_npc_q : upd_pc + ADDR_W'(4);
    mispredict    = upd_valid & ((upd_taken != id_pred_taken) |
                                 (upd_taken & (upd_target != id_pred_npc)));
    recover_pc    = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
  end

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat (
    .ctr_i     (upd_ctr_cur),
    .taken     (upd_taken),
    .force_max (upd_jump),
    .ctr_o     (upd_ctr_nxt)
  );

  // Table update: train on a hit, allocate on a taken miss, ignore a not-taken miss.
  always_comb begin
    btb_d       = btb_q;
    upd_ctr_cur = CTR_BITS'(btb_q[upd_idx].ctr);
    upd_hit     = btb_q[upd_idx].valid & (btb_q[upd_idx].tag == BTB_ADDR_MAX'(upd_tag));
    if (USE_BTB && upd_valid) begin
      if (upd_hit) begin
        btb_d[upd_idx].ctr = BTB_CTR_MAX'(upd_ctr_nxt);
        btb_d[upd_idx].jmp = upd_jump;
        if (upd_taken) btb_d[upd_idx].target = BTB_ADDR_MAX'(upd_target);
      end else if (upd_taken) begin
        btb_d[upd_idx] = '{
          valid:  1'b1,
          jmp:    upd_jump,
          tag:    BTB_ADDR_MAX'(upd_tag),
          target: BTB_ADDR_MAX'(upd_target),
          ctr:    BTB_CTR_MAX'(upd_jump ? CTR_MAX_V : CTR_WT_V)
        };
      end
    end
  end

  // Shadow next state: a flush or mispredict squashes, a stall holds, otherwise load.
  // The resolving PC arrives on upd_pc, so the IF PC itself is not carried.
  always_comb begin
    shadow_valid_d = shadow_valid_q;
    shadow_taken_d = shadow_taken_q;
    shadow_npc_d   = shadow_npc_q;
    if (id_flush || mispredict) begin
      shadow_valid_d = 1'b0;
    end else if (!if_stall) begin
      shadow_valid_d = lk_valid;
      shadow_taken_d = pred_taken;
      shadow_npc_d   = next_pc;
    end
  end

  // Statistics next state; both counters wrap naturally.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid)  stat_br_d = stat_br_q + STAT_W'(1);
    if (mispredict) stat_mp_d = stat_mp_q + STAT_W'(1);
  end

  // State registers, synchronous active-low reset on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb_q[i] <= ENTRY_RST;
      shadow_valid_q <= 1'b0;
      shadow_taken_q <= 1'b0;
      shadow_npc_q   <= '0;
      stat_br_q      <= '0;
      stat_mp_q      <= '0;
    end else begin
      btb_q          <= btb_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_taken_q <= shadow_taken_d;
      shadow_npc_q   <= shadow_npc_d;
      stat_br_q      <= stat_br_d;
      stat_mp_q      <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic,
// run against a bimodal instance and a static not-taken instance side by side.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        if_stall, id_flush;
  logic        upd_valid, upd_taken, upd_jump;
  logic [31:0] upd_pc, upd_target;

  logic        pt1, mp1, pt0, mp0;
  logic [31:0] np1, rc1, sb1, sm1, np0, rc0, sb0, sm0;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_BITS(2), .STAT_W(32), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_taken(pt1), .next_pc(np1), .if_stall(if_stall), .id_flush(id_flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_jump(upd_jump), .mispredict(mp1),
    .recover_pc(rc1), .stat_branches(sb1), .stat_mispredicts(sm1));

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_BITS(2), .STAT_W(32), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_taken(pt0), .next_pc(np0), .if_stall(if_stall), .id_flush(id_flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_jump(upd_jump), .mispredict(mp0),
    .recover_pc(rc0), .stat_branches(sb0), .stat_mispredicts(sm0));

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // Reference model: table of 16 entries, counter as plain integer 0..3.
  bit          m_valid [16];
  bit          m_jmp   [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  bit          m_known = 0;
  bit          s1_v, s1_t, s0_v;
  int unsigned s1_n, s0_n;
  int unsigned m_br, m_mp1, m_mp0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rstn, input bit lkv, input int unsigned lkpc,
                       input bit stl, input bit fl, input bit uv, input int unsigned upc,
                       input bit ut, input int unsigned utg, input bit uj);
    int unsigned li, lt, ui, utag, e_np1, e_rc, pn1, pn0;
    bit hit_l, e_pt1, e_mp1, e_mp0, hit_u;
    rst_n = rstn; lk_valid = lkv; lk_pc = lkpc; if_stall = stl; id_flush = fl;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_jump = uj;
    #1;
    li    = (lkpc >> 2) % 16;
    lt    = lkpc >> 6;
    hit_l = lkv && m_valid[li] && (m_tag[li] == lt);
    e_pt1 = hit_l && (m_ctr[li] >= 2 || m_jmp[li]);
    e_np1 = e_pt1 ? m_tgt[li] : lkpc + 4;
    pn1   = s1_v ? s1_n : upc + 4;
    pn0   = s0_v ? s0_n : upc + 4;
    e_mp1 = uv && ((ut != (s1_v && s1_t)) || (ut && utg != pn1));
    e_mp0 = uv && (ut || (ut && utg != pn0));
    e_rc  = ut ? utg : upc + 4;
    if (m_known) begin
      chk("pred_taken", 32'(pt1), 32'(e_pt1));
      chk("next_pc", np1, e_np1);
      chk("mispredict", 32'(mp1), 32'(e_mp1));
      chk("recover_pc", rc1, e_rc);
      chk("stat_branches", sb1, m_br);
      chk("stat_mispredicts", sm1, m_mp1);
      chk("m0_pred_taken", 32'(pt0), 32'd0);
      chk("m0_next_pc", np0, lkpc + 4);
      chk("m0_mispredict", 32'(mp0), 32'(e_mp0));
      chk("m0_recover_pc", rc0, e_rc);
      chk("m0_stat_branches", sb0, m_br);
      chk("m0_stat_mispredicts", sm0, m_mp0);
    end
    @(negedge clk);
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_jmp[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
      end
      s1_v = 0; s0_v = 0; s1_t = 0; s1_n = 0; s0_n = 0;
      m_br = 0; m_mp1 = 0; m_mp0 = 0;
      m_known = 1;
    end else begin
      if (fl || e_mp1) s1_v = 0;
      else if (!stl) begin s1_v = lkv; s1_t = e_pt1; s1_n = e_np1; end
      if (fl || e_mp0) s0_v = 0;
      else if (!stl) begin s0_v = lkv; s0_n = lkpc + 4; end
      if (uv) begin
        ui    = (upc >> 2) % 16;
        utag  = upc >> 6;
        hit_u = m_valid[ui] && (m_tag[ui] == utag);
        if (hit_u) begin
          if (uj) m_ctr[ui] = 3;
          else if (ut) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          else m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          if (ut) m_tgt[ui] = utg;
          m_jmp[ui] = uj;
        end else if (ut) begin
          m_valid[ui] = 1; m_tag[ui] = utag; m_tgt[ui] = utg; m_jmp[ui] = uj;
          m_ctr[ui] = uj ? 3 : 2;
        end
        m_br++;
      end
      if (e_mp1) m_mp1++;
      if (e_mp0) m_mp0++;
    end
    #1;
  endtask

  task automatic look(input int unsigned pc);
    cycle(1, 1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int unsigned pc, input bit t, input int unsigned tg);
    cycle(1, 0, 0, 0, 0, 1, pc, t, tg, 0);
  endtask

  int unsigned pcs  [6] = '{32'h40, 32'h80, 32'h44, 32'h100, 32'h3C, 32'hC0};
  int unsigned tgts [4] = '{32'h100, 32'h200, 32'h44, 32'h84};

  initial begin
    // Reset and first lookup
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_pt_reset", 32'(pt1), 32'd0);
    chk("t1_npc_reset", np1, 32'h44);
    chk("t1_stats_reset", sb1, 32'd0);

    // Allocate on taken, then hit
    upd(32'h40, 1, 32'h100);
    rst_n = 1; lk_valid = 1; lk_pc = 32'h40; upd_valid = 0; #1;
    chk("t2_pt_hit", 32'(pt1), 32'd1);
    chk("t2_npc_hit", np1, 32'h100);
    look(32'h40);

    // Training and saturation on 0x40
    cycle(1, 1, 32'h40, 0, 0, 1, 32'h40, 0, 0, 0);
    cycle(1, 1, 32'h40, 0, 0, 1, 32'h40, 0, 0, 0);
    look(32'h40);
    repeat (2) upd(32'h40, 0, 0);
    look(32'h40);
    repeat (4) upd(32'h40, 1, 32'h100);
    look(32'h40);
    upd(32'h40, 0, 0);
    look(32'h40);
    upd(32'h40, 0, 0);
    look(32'h40);

    // Aliasing on index 0
    repeat (2) upd(32'h40, 1, 32'h100);
    look(32'h40);
    look(32'h80);
    upd(32'h80, 1, 32'h200);
    look(32'h40);
    look(32'h80);

    // Mispredict with recovery, then shadow cleared
    upd(32'h40, 1, 32'h100);
    look(32'h40);
    rst_n = 1; lk_valid = 0; upd_valid = 1; upd_pc = 32'h40; upd_taken = 0; #1;
    chk("t5_mispredict", 32'(mp1), 32'd1);
    chk("t5_recover", rc1, 32'h44);
    upd(32'h40, 0, 0);
    upd(32'h48, 0, 0);
    // Same again with the shadow held by a 2-cycle stall
    repeat (2) upd(32'h40, 1, 32'h100);
    look(32'h40);
    repeat (2) cycle(1, 1, 32'h50, 1, 0, 0, 0, 0, 0, 0);
    upd(32'h40, 0, 0);
    look(32'h40);
    cycle(1, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0);
    upd(32'h40, 1, 32'h100);

    // Mid-run reset wipes training; same-cycle lookup/update sees old contents
    repeat (2) upd(32'h40, 1, 32'h100);
    repeat (3) cycle(0, 1, 32'h40, 0, 0, 1, 32'h40, 1, 32'h100, 0);
    cycle(1, 1, 32'h40, 0, 0, 1, 32'h40, 1, 32'h100, 0);
    rst_n = 1; lk_valid = 1; lk_pc = 32'h40; upd_valid = 0; #1;
    chk("t6_pt_after", 32'(pt1), 32'd1);
    chk("t6_m0_pt", 32'(pt0), 32'd0);
    chk("t6_m0_branches", sb0, 32'd1);
    look(32'h40);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      bit r_rst, r_lkv, r_stl, r_fl, r_uv, r_ut, r_uj;
      r_rst = ($urandom_range(0, 99) == 0);
      r_lkv = $urandom_range(0, 3) != 0;
      r_stl = $urandom_range(0, 6) == 0;
      r_fl  = $urandom_range(0, 9) == 0;
      r_uv  = $urandom_range(0, 1) != 0;
      r_uj  = $urandom_range(0, 9) == 0;
      r_ut  = r_uj || ($urandom_range(0, 1) != 0);
      cycle(!r_rst, r_lkv, pcs[$urandom_range(0, 5)], r_stl, r_fl,
            r_uv, pcs[$urandom_range(0, 5)], r_ut, tgts[$urandom_range(0, 3)], r_uj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
